// File: rtl/joy_serial_scanner.sv
// Serial joystick scanner: drives a daisy-chained parallel-in/serial-out
// shift-register chain, decodes the active-low button bits into JOY_OUT,
// or passes an external master straight through to the chain in forward mode.
module joy_serial_scanner #(
    parameter int NUM_CH      = 2,
    parameter int BITS_PER_CH = 12,
    parameter int CLK_DIV     = 25,
    parameter int SCAN_GAP    = 64
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    input  logic                          MODE,
    input  logic                          XJOY_CLK,
    input  logic                          XJOY_LOAD_N,
    input  logic                          JOY_DATA,
    output logic                          JOY_CLK,
    output logic                          JOY_LOAD_N,
    output logic                          XJOY_DATA,
    output logic [NUM_CH*BITS_PER_CH-1:0] JOY_OUT,
    output logic                          JOY_VALID
);

    localparam int N  = NUM_CH * BITS_PER_CH;
    localparam int PW = $clog2(CLK_DIV);
    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SAMPLE = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [GW-1:0]   gap_q;
    logic [IW-1:0]   idx_q;
    logic [1:0]      sync_q;
    logic [N-1:0]    capture_q;
    logic [N-1:0]    joy_out_q;
    logic            joy_valid_q;
    logic            joy_clk_q;
    logic            joy_load_n_q;
    logic            mode_q;

    logic tick;
    logic mode_chg;
    logic data_s;

    assign tick     = (presc_q == PW'(CLK_DIV - 1));
    assign mode_chg = MODE ^ mode_q;
    assign data_s   = sync_q[1];

    // Prescaler next value. It is frozen during the single DONE cycle so the
    // following IDLE period starts on a full tick; this is what makes the scan
    // period come out as a whole number of ticks plus exactly one cycle.
    always_comb begin
        presc_d = presc_q;
        if (mode_chg)
            presc_d = '0;
        else if (state_q == DONE)
            presc_d = presc_q;
        else if (tick)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) presc_q <= '0;
        else          presc_q <= presc_d;
    end

    // Two-stage synchroniser on the chain's serial data; idles high (released).
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], JOY_DATA};
    end

    // Scan FSM with registered chain controls; forward mode or any MODE edge
    // parks it in IDLE with a fresh gap count, discarding a partial capture.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            idx_q        <= '0;
            capture_q    <= '0;
            joy_out_q    <= '0;
            joy_valid_q  <= 1'b0;
            joy_clk_q    <= 1'b0;
            joy_load_n_q <= 1'b1;
            mode_q       <= 1'b0;
        end else begin
            mode_q      <= MODE;
            joy_valid_q <= 1'b0;
            if (MODE || mode_chg) begin
                state_q      <= IDLE;
                gap_q        <= '0;
                idx_q        <= '0;
                joy_clk_q    <= 1'b0;
                joy_load_n_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tick) begin
                            if (gap_q == GW'(SCAN_GAP - 1)) begin
                                gap_q        <= '0;
                                state_q      <= LOAD;
                                joy_load_n_q <= 1'b0;
                            end else begin
                                gap_q <= gap_q + 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        if (tick) begin
                            idx_q        <= '0;
                            state_q      <= SAMPLE;
                            joy_load_n_q <= 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (tick) begin
                            capture_q[idx_q] <= ~data_s;
                            if (idx_q == IW'(N - 1)) begin
                                state_q <= DONE;
                            end else begin
                                state_q   <= SHIFT;
                                joy_clk_q <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (tick) begin
                            idx_q     <= idx_q + 1'b1;
                            state_q   <= SAMPLE;
                            joy_clk_q <= 1'b0;
                        end
                    end
                    DONE: begin
                        joy_out_q   <= capture_q;
                        joy_valid_q <= 1'b1;
                        gap_q       <= '0;
                        state_q     <= IDLE;
                    end
                    default: begin
                        state_q      <= IDLE;
                        gap_q        <= '0;
                        joy_clk_q    <= 1'b0;
                        joy_load_n_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Forward mode is a pure combinational bypass, no added latency.
    assign JOY_CLK    = MODE ? XJOY_CLK    : joy_clk_q;
    assign JOY_LOAD_N = MODE ? XJOY_LOAD_N : joy_load_n_q;
    assign XJOY_DATA  = MODE ? JOY_DATA    : 1'b1;
    assign JOY_OUT    = joy_out_q;
    assign JOY_VALID  = joy_valid_q;

endmodule

// File: doc/joy_serial_scanner.md
JOY_SERIAL_SCANNER -- requirements
Module: joy_serial_scanner

Interface
REQ-001 Parameter NUM_CH, default 2, number of daisy-chained joystick shift-register channels (1..4).
REQ-002 Parameter BITS_PER_CH, default 12, bits per channel (1..16).
REQ-003 Parameter CLK_DIV, default 25, CLOCK_50 cycles per tick (>=4).
REQ-004 Parameter SCAN_GAP, default 64, idle ticks between scans (>=1).
REQ-005 Derived N = NUM_CH*BITS_PER_CH.
REQ-006 Port CLOCK_50, input, 1: sole clock; all logic on rising edge.
REQ-007 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-008 Port MODE, input, 1: 0 = master scan, 1 = forward (pass-through).
REQ-009 Port XJOY_CLK, input, 1: external master shift clock, forward mode only.
REQ-010 Port XJOY_LOAD_N, input, 1: external master load strobe, forward mode only.
REQ-011 Port JOY_DATA, input, 1: serial data from the shift-register chain, active-low buttons.
REQ-012 Port JOY_CLK, output, 1: shift clock to the chain.
REQ-013 Port JOY_LOAD_N, output, 1: parallel-load strobe to the chain, active-low.
REQ-014 Port XJOY_DATA, output, 1: serial data returned to the external master.
REQ-015 Port JOY_OUT, output, N: decoded button state, 1 = pressed; channel c occupies JOY_OUT[c*BITS_PER_CH +: BITS_PER_CH].
REQ-016 Port JOY_VALID, output, 1: one-cycle pulse when JOY_OUT updates.

Function
REQ-017 The prescaler shall count 0..CLK_DIV-1 and emit a one-cycle tick at CLK_DIV-1; it shall clear to 0 on any MODE change.
REQ-018 JOY_DATA shall pass through a 2-FF synchroniser before capture; the fixed latency is 2 cycles.
REQ-019 In master mode, the FSM shall implement states IDLE, LOAD, SAMPLE, SHIFT, DONE, with registered outputs.
REQ-020 IDLE: JOY_LOAD_N=1, JOY_CLK=0; the state shall count SCAN_GAP ticks, then go to LOAD.
REQ-021 LOAD: JOY_LOAD_N=0, JOY_CLK=0 for one tick period; next state SAMPLE, with bit index cleared to 0.
REQ-022 SAMPLE: JOY_LOAD_N=1, JOY_CLK=0; at the tick, it shall capture ~JOY_DATA_sync into capture[idx]; if idx==N-1 go to DONE, else go to SHIFT.
REQ-023 SHIFT: JOY_CLK=1 for one tick period; at the tick, idx shall increment and the FSM shall return to SAMPLE.
REQ-024 DONE: lasts one cycle; JOY_OUT<=capture, JOY_VALID=1; next state IDLE with the gap counter cleared.
REQ-025 Bit order: first sampled bit -> JOY_OUT[0]; last bit -> JOY_OUT[N-1].
REQ-026 Scan period: exactly (SCAN_GAP + 1 + 2N - 1) ticks plus 1 cycle between consecutive JOY_VALID pulses.
REQ-027 In master mode, XJOY_DATA shall be 1.
REQ-028 In forward mode:
  - JOY_CLK=XJOY_CLK, JOY_LOAD_N=XJOY_LOAD_N and XJOY_DATA=JOY_DATA, combinationally with no added latency.
  - The FSM shall be held in IDLE.
  - JOY_OUT shall hold its last value and JOY_VALID shall stay 0.
REQ-029 A MODE change mid-scan shall abort the scan and return the FSM to IDLE; JOY_OUT shall not update and no JOY_VALID pulse shall be issued.
REQ-030 A partially captured scan shall never reach JOY_OUT; JOY_OUT updates only in DONE.
REQ-031 Leaving forward mode shall restart the IDLE gap count from 0.

Reset
REQ-032 While RESET_N=0, the block shall immediately force:
  - state=IDLE, idx=0, prescaler=0, gap counter=0, synchroniser=11;
  - JOY_OUT=0, capture=0, JOY_VALID=0;
  - registered JOY_CLK=0, JOY_LOAD_N=1.
REQ-033 Reset asserted mid-scan shall discard the capture; after release, the block shall resume with a full SCAN_GAP idle period.

Verification (NUM_CH=2, BITS_PER_CH=12, CLK_DIV=4, SCAN_GAP=8, MODE=0 unless stated)
REQ-034 Chain model loaded with pattern 0xFFE_7FE (active-low) -> JOY_VALID pulse with JOY_OUT=0x001_801, and exactly 23 JOY_CLK rising edges and 1 JOY_LOAD_N low pulse of 4 cycles per scan.
REQ-035 Free-running scans -> successive JOY_VALID pulses exactly (8+1+47)*4+1 = 225 cycles apart; JOY_CLK high and low phases are each 4 cycles.
REQ-036 MODE=1 with XJOY_CLK/XJOY_LOAD_N toggled randomly -> JOY_CLK/JOY_LOAD_N mirror them in the same cycle, XJOY_DATA mirrors JOY_DATA, JOY_OUT is unchanged and JOY_VALID stays 0.
REQ-037 MODE 0->1 at bit 10, then back to 0 -> no JOY_VALID for the aborted scan; the next scan starts after 8 idle ticks and reports the correct pattern.
REQ-038 RESET_N pulsed low during SHIFT at bit 15 -> outputs take their reset values asynchronously, JOY_OUT=0, and the first post-reset JOY_VALID carries a complete, correct scan.
